// File: rtl/rsa_pkg.sv
// Shared constants and FSM encoding for the Montgomery constant generator.
package rsa_pkg;

    localparam int DEF_WIDTH = 1024;
    localparam int DEF_WORD  = 32;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DBL_R  = 2'd1,
        DBL_R2 = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Width of an iteration counter able to hold 0..w.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mod_double.sv
// Combinational modular doubling: y = 2x mod n, assuming x < n.
// Works on WIDTH+1 bits so 2x never overflows.
module mod_double #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   x,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH:0]   y
);

    logic [WIDTH:0] dbl;
    logic [WIDTH:0] n_ext;

    // Since x < n < 2^WIDTH, 2x fits and one conditional subtract suffices.
    always_comb begin
        dbl   = x << 1;
        n_ext = {1'b0, n};
        y     = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
    end

endmodule

// File: rtl/mont_const_gen.sv
// Montgomery pre-computation: R mod N, R^2 mod N and -N^-1 mod 2^WORD,
// with R = 2^WIDTH. Both remainders come from one modular-doubling chain.
module mont_const_gen
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WORD  = DEF_WORD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] r_mod,
    output logic [WIDTH-1:0] r2_mod,
    output logic [WORD-1:0]  n_prime
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH:0]   x;
    logic [WIDTH:0]   x_nxt;
    logic [CW-1:0]    cnt;
    logic [WORD-1:0]  y;
    logic [WORD-1:0]  y_nxt;
    logic [WORD-1:0]  mask;
    logic [WORD-1:0]  prod;
    logic             n_ok;

    mod_double #(.WIDTH(WIDTH)) u_dbl (
        .x (x),
        .n (n_reg),
        .y (x_nxt)
    );

    assign n_ok = modulus[0] && (modulus >= WIDTH'(3));

    // Hensel lifting: mask walks bit 1..WORD-1 and then shifts out, which
    // freezes y at N^-1 mod 2^WORD without a separate stop condition.
    always_comb begin
        prod  = n_reg[WORD-1:0] * y;
        y_nxt = (|(prod & mask)) ? (y | mask) : y;
    end

    // Control FSM and all result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            n_reg   <= '0;
            x       <= '0;
            cnt     <= '0;
            y       <= '0;
            mask    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            r_mod   <= '0;
            r2_mod  <= '0;
            n_prime <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (n_ok) begin
                            n_reg <= modulus;
                            x     <= {{WIDTH{1'b0}}, 1'b1};
                            cnt   <= '0;
                            y     <= WORD'(1);
                            mask  <= WORD'(2);
                            busy  <= 1'b1;
                            error <= 1'b0;
                            state <= DBL_R;
                        end else begin
                            error <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                DBL_R: begin
                    x    <= x_nxt;
                    y    <= y_nxt;
                    mask <= mask << 1;
                    if (cnt == LAST) begin
                        r_mod <= x_nxt[WIDTH-1:0];
                        cnt   <= '0;
                        state <= DBL_R2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DBL_R2: begin
                    x <= x_nxt;
                    if (cnt == LAST) begin
                        r2_mod <= x_nxt[WIDTH-1:0];
                        cnt    <= '0;
                        state  <= FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FINISH: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    // error doubles as the "rejected N" flag: keep old n_prime
                    if (!error) n_prime <= '0 - y;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_const_gen.sv
// Directed bench for mont_const_gen: one 8-bit and one 16-bit instance.
module tb_mont_const_gen;

    logic        clk;
    logic        rst_n;
    logic        start8, start16;
    logic [7:0]  mod8;
    logic [15:0] mod16;
    logic        busy8, done8, err8;
    logic [7:0]  r8, r28, np8;
    logic        busy16, done16, err16;
    logic [15:0] r16, r216, np16;

    int n_cmp;
    int n_err;

    mont_const_gen #(.WIDTH(8), .WORD(8)) d8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .modulus(mod8),
        .busy(busy8), .done(done8), .error(err8),
        .r_mod(r8), .r2_mod(r28), .n_prime(np8)
    );

    mont_const_gen #(.WIDTH(16), .WORD(16)) d16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .modulus(mod16),
        .busy(busy16), .done(done16), .error(err16),
        .r_mod(r16), .r2_mod(r216), .n_prime(np16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Start the 8-bit instance; lat = edges after acceptance until done seen.
    task automatic go8(input logic [7:0] n, output int lat, output logic bsy);
        @(negedge clk);
        start8 = 1'b1;
        mod8   = n;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        bsy    = busy8;
        lat    = 0;
        while (!done8 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic go16(input logic [15:0] n, output int lat);
        @(negedge clk);
        start16 = 1'b1;
        mod16   = n;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        lat     = 0;
        while (!done16 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    initial begin
        int   lat;
        logic bsy;
        int   ndone, done_e, gap;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start8 = 1'b0; start16 = 1'b0;
        mod8 = 8'h00;  mod16 = 16'h0000;
        repeat (2) @(negedge clk);

        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_r", r8, 0);
        chk("rst_np16", np16, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // case 1
        go8(8'hC5, lat, bsy);
        chk("c1_busy", bsy, 1);
        chk("c1_lat", lat, 17);
        chk("c1_r", r8, 8'h3B);
        chk("c1_r2", r28, 8'h84);
        chk("c1_np", np8, 8'hF3);
        chk("c1_err", err8, 0);
        chk("c1_busy_at_done", busy8, 0);
        @(negedge clk);
        chk("c1_done_pulse", done8, 0);

        // case 2
        go8(8'hFF, lat, bsy);
        chk("c2_lat", lat, 17);
        chk("c2_r", r8, 8'h01);
        chk("c2_r2", r28, 8'h01);
        chk("c2_np", np8, 8'h01);

        // case 3
        go16(16'h8001, lat);
        chk("c3_lat", lat, 33);
        chk("c3_r", r16, 16'h7FFF);
        chk("c3_r2", r216, 16'h0004);
        chk("c3_np", np16, 16'h7FFF);
        chk("c3_err", err16, 0);

        // case 4: rejected moduli keep previous results
        go8(8'h10, lat, bsy);
        chk("c4a_lat", lat, 1);
        chk("c4a_err", err8, 1);
        chk("c4a_r", r8, 8'h01);
        chk("c4a_np", np8, 8'h01);
        go8(8'h01, lat, bsy);
        chk("c4b_lat", lat, 1);
        chk("c4b_err", err8, 1);
        chk("c4b_r2", r28, 8'h01);
        @(negedge clk);
        chk("c4_err_held", err8, 1);

        // case 5: restart and modulus change mid-run are ignored
        @(negedge clk);
        start8 = 1'b1;
        mod8   = 8'hC5;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        ndone = 0; done_e = 0; gap = 0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) begin
                ndone++;
                if (done_e == 0) done_e = e;
            end else if (!busy8 && ndone == 0) begin
                gap++;
            end
            if (e == 4) begin
                start8 = 1'b1;
                mod8   = 8'hFF;
            end
            if (e == 5) start8 = 1'b0;
        end
        chk("c5_ndone", ndone, 1);
        chk("c5_done_e", done_e, 17);
        chk("c5_busy_gap", gap, 0);
        chk("c5_r", r8, 8'h3B);
        chk("c5_r2", r28, 8'h84);
        chk("c5_np", np8, 8'hF3);
        chk("c5_err", err8, 0);

        // case 6: asynchronous reset mid-run
        @(negedge clk);
        start8 = 1'b1;
        mod8   = 8'hC5;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("c6_busy", busy8, 0);
        chk("c6_r", r8, 0);
        chk("c6_r2", r28, 0);
        chk("c6_np", np8, 0);
        chk("c6_np16", np16, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        chk("c6_idle", ndone, 0);
        go8(8'hC5, lat, bsy);
        chk("c6_lat", lat, 17);
        chk("c6_r_after", r8, 8'h3B);
        chk("c6_r2_after", r28, 8'h84);
        chk("c6_np_after", np8, 8'hF3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
